// File: rtl/fft_ctrl_pkg.sv
//==================================================================
// fft_ctrl_pkg: shared constants and state type for FFT control, rev 1.0
//==================================================================
`default_nettype none

package fft_ctrl_pkg;

  localparam int BEATS_PER_FRAME_DEF = 32;
  localparam int BEAT_CNT_W          = $clog2(BEATS_PER_FRAME_DEF);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FEED = 1'b1
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/fft_beat_counter.sv
//==================================================================
// fft_beat_counter: modulo beat counter with same-cycle wrap strobe, rev 1.0
//==================================================================
`default_nettype none

module fft_beat_counter #(
  parameter int MODULUS = 32,
  parameter int W       = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] C_LAST = W'(MODULUS - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    wrap_o = en_i && (cnt_q == C_LAST);
    cnt_d  = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/fft_stage1_sequencer.sv
//==================================================================
// fft_stage1_sequencer: stage-1 frame sequencing and buffer credits, rev 1.0
//==================================================================
`default_nettype none

module fft_stage1_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int BEATS_PER_FRAME = BEATS_PER_FRAME_DEF,
  parameter int MAX_INFLIGHT    = 2,
  parameter int FCNT_W          = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                src_valid_i,
  input  logic                                src_sop_i,
  output logic                                src_ready_o,
  output logic                                pipe_valid_o,
  input  logic                                pipe_done_i,
  input  logic                                credit_ret_i,
  input  logic                                sw_clr_i,
  output logic                                out_sop_o,
  output logic                                out_eop_o,
  output logic [FCNT_W-1:0]                   frame_cnt_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_o,
  output logic [$clog2(BEATS_PER_FRAME)-1:0]  in_cnt_o,
  output logic                                busy_o,
  output logic                                err_gap_o,
  output logic                                err_sop_o,
  output logic                                err_credit_o
);

  localparam int BCW = $clog2(BEATS_PER_FRAME);
  localparam int IW  = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0] C_MAX_IF = IW'(MAX_INFLIGHT);

  seq_state_e        state_q, state_d;
  logic [IW-1:0]     inflight_q, inflight_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              err_gap_q, err_gap_d;
  logic              err_sop_q, err_sop_d;
  logic              err_credit_q, err_credit_d;

  logic              w_idle;
  logic              w_ready;
  logic              w_accept;
  logic              w_fwd;
  logic              w_start;
  logic              w_credit_bad;
  logic              w_in_wrap;
  logic              w_out_wrap;
  logic [BCW-1:0]    w_in_cnt;
  logic [BCW-1:0]    w_out_cnt;

  assign w_idle   = (state_q == ST_IDLE);
  // Outputs are forced low while rst is held, independent of the clock.
  assign w_ready  = !rst && (w_idle ? (inflight_q < C_MAX_IF) : 1'b1);
  assign w_accept = src_valid_i && w_ready;
  assign w_fwd    = w_accept && !(w_idle && !src_sop_i);
  assign w_start  = w_fwd && w_idle;

  fft_beat_counter #(
    .MODULUS (BEATS_PER_FRAME),
    .W       (BCW)
  ) u_in_cnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (w_fwd),
    .cnt_o  (w_in_cnt),
    .wrap_o (w_in_wrap)
  );

  fft_beat_counter #(
    .MODULUS (BEATS_PER_FRAME),
    .W       (BCW)
  ) u_out_cnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (pipe_done_i),
    .cnt_o  (w_out_cnt),
    .wrap_o (w_out_wrap)
  );

  always_comb begin
    state_d      = state_q;
    inflight_d   = inflight_q;
    w_credit_bad = 1'b0;
    case (state_q)
      ST_IDLE: if (w_start)   state_d = ST_FEED;
      ST_FEED: if (w_in_wrap) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
    if (w_start && !credit_ret_i) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!w_start && credit_ret_i) begin
      if (inflight_q != '0) begin
        inflight_d = inflight_q - 1'b1;
      end else begin
        w_credit_bad = 1'b1;
      end
    end
    frame_cnt_d  = frame_cnt_q + {{(FCNT_W-1){1'b0}}, w_out_wrap};
    // A fresh error in the clear cycle keeps the flag set.
    err_gap_d    = (!w_idle && !src_valid_i) || (err_gap_q && !sw_clr_i);
    err_sop_d    = (w_accept && (w_idle ? !src_sop_i : src_sop_i))
                   || (err_sop_q && !sw_clr_i);
    err_credit_d = w_credit_bad || (err_credit_q && !sw_clr_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      inflight_q   <= '0;
      frame_cnt_q  <= '0;
      err_gap_q    <= 1'b0;
      err_sop_q    <= 1'b0;
      err_credit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      frame_cnt_q  <= frame_cnt_d;
      err_gap_q    <= err_gap_d;
      err_sop_q    <= err_sop_d;
      err_credit_q <= err_credit_d;
    end
  end

  assign src_ready_o  = w_ready;
  assign pipe_valid_o = w_fwd;
  assign out_sop_o    = !rst && pipe_done_i && (w_out_cnt == '0);
  assign out_eop_o    = !rst && w_out_wrap;
  assign busy_o       = !rst && (!w_idle || (inflight_q != '0));
  assign frame_cnt_o  = frame_cnt_q;
  assign inflight_o   = inflight_q;
  assign in_cnt_o     = w_in_cnt;
  assign err_gap_o    = err_gap_q;
  assign err_sop_o    = err_sop_q;
  assign err_credit_o = err_credit_q;

endmodule

`default_nettype wire
